rr_dispatcher: RTL and testbench

Round-robin dispatcher for the load balancer: accepts a single valid/ready input stream of work words and hands each word to one of 2^SEL_BITS output lanes in strict rotation. The lane pointer is the existing `upcounter`; this block is its direct consumer, driving its `enable` and using `count`/`max_tick`. A one-entry holding register decouples input from lanes. A stall timeout skips a lane that stops accepting.

---
 rtl/lb_dispatch_pkg.sv | 25 ++
 rtl/upcounter.sv | 25 ++
 rtl/rr_dispatcher.sv | 104 ++++++++++
 tb/tb_rr_dispatcher.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/lb_dispatch_pkg.sv
// Shared types and helpers for the load-balancer dispatch blocks.
package lb_dispatch_pkg;

  // Holding-register occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Number of lanes addressed by a lane index of the given width.
  function automatic int lane_count(input int sel_bits);
    return 1 << sel_bits;
  endfunction

endpackage

// File: rtl/upcounter.sv
// Free-running up counter with enable; wraps naturally at all-ones.
module upcounter #(
  parameter int COUNT_BITS = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  output logic [COUNT_BITS-1:0] count,
  output logic                  max_tick
);

  // Count register: advance by one whenever enabled.
  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples
    // pre-edge values and the simulation matches the synthesized netlist.
    if (!resetn) begin
      count <= '0;
    end else if (enable) begin
      count <= count + COUNT_BITS'(1);
    end
  end

  assign max_tick = &count;

endmodule

// File: rtl/rr_dispatcher.sv
// Round-robin dispatcher: one input stream, one-entry holding register,
// words handed to 2^SEL_BITS lanes in strict rotation with stall skipping.
module rr_dispatcher
  import lb_dispatch_pkg::*;
#(
  parameter int DATA_BITS   = 32,
  parameter int SEL_BITS    = 2,
  parameter int STALL_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_BITS-1:0]     s_data,
  output logic [(1<<SEL_BITS)-1:0] m_valid,
  input  logic [(1<<SEL_BITS)-1:0] m_ready,
  output logic [DATA_BITS-1:0]     m_data,
  output logic [SEL_BITS-1:0]      m_sel,
  output logic                     round_tick
);

  localparam int LANES      = lane_count(SEL_BITS);
  localparam int STALL_BITS = (clog2(STALL_LIMIT + 1) < 1) ? 1 : clog2(STALL_LIMIT + 1);
  localparam bit SKIP_EN    = (STALL_LIMIT != 0);
  // Stall count value in the last refused cycle before the pointer moves on.
  localparam logic [STALL_BITS-1:0] STALL_LAST =
    STALL_BITS'((STALL_LIMIT == 0) ? 0 : STALL_LIMIT - 1);

  state_t                state_q;
  state_t                state_d;
  logic [DATA_BITS-1:0]  hold_q;
  logic [STALL_BITS-1:0] stall_cnt;
  logic [SEL_BITS-1:0]   sel;
  logic                  max_tick;
  logic                  full;
  logic                  lane_ready;
  logic                  fire;
  logic                  skip;
  logic                  accept;
  logic                  advance;

  // Outputs are forced idle while reset is held, even before the first edge.
  assign full       = resetn & (state_q == ST_FULL);
  assign lane_ready = m_ready[sel];
  assign fire       = full & lane_ready;
  assign skip       = SKIP_EN & full & ~lane_ready & (stall_cnt == STALL_LAST);
  assign s_ready    = resetn & (~full | fire);
  assign accept     = s_valid & s_ready;
  assign advance    = fire | skip;

  assign m_valid    = full ? (LANES'(1) << sel) : '0;
  assign m_data     = hold_q;
  assign m_sel      = sel;
  assign round_tick = fire & max_tick;

  // Lane pointer; advances once per handoff or skip.
  upcounter #(
    .COUNT_BITS(SEL_BITS)
  ) u_lane_ptr (
    .clk     (clk),
    .resetn  (resetn),
    .enable  (advance),
    .count   (sel),
    .max_tick(max_tick)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_EMPTY;
    else         state_q <= state_d;
  end

  // FSM next state: fill on accept, drain when a handoff is not refilled.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_d unassigned,
    // which would infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (accept)          state_d = ST_FULL;
      ST_FULL:  if (fire && !accept) state_d = ST_EMPTY;
      default:                       state_d = ST_EMPTY;
    endcase
  end

  // Holding register: capture each accepted word.
  always_ff @(posedge clk) begin
    // NOTE: this datapath register is reset on purpose so m_data reads 0
    // out of reset and a discarded word can never reappear.
    if (!resetn)     hold_q <= '0;
    else if (accept) hold_q <= s_data;
  end

  // Stall counter: consecutive refused cycles on the current lane.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if (!full || fire || skip) begin
      stall_cnt <= '0;
    end else if (SKIP_EN) begin
      stall_cnt <= stall_cnt + STALL_BITS'(1);
    end
  end

endmodule

// File: tb/tb_rr_dispatcher.sv
// Self-checking bench for rr_dispatcher: directed vector table followed by
// randomized traffic compared against a behavioural model.
module tb_rr_dispatcher;

  localparam int DB = 8;
  localparam int SB = 2;
  localparam int SL = 3;
  localparam int N  = 1 << SB;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DB-1:0] s_data = '0;
  logic [N-1:0]  m_valid;
  logic [N-1:0]  m_ready = '0;
  logic [DB-1:0] m_data;
  logic [SB-1:0] m_sel;
  logic          round_tick;

  int tests  = 0;
  int failed = 0;

  rr_dispatcher #(
    .DATA_BITS  (DB),
    .SEL_BITS   (SB),
    .STALL_LIMIT(SL)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_sel     (m_sel),
    .round_tick(round_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rn;
    logic          sv;
    logic [DB-1:0] sd;
    logic [N-1:0]  mr;
    logic          e_srdy;
    logic [N-1:0]  e_mv;
    logic [SB-1:0] e_sel;
    logic          e_tick;
    logic [DB-1:0] e_data;
    logic [1:0]    e_stall;
    bit            chk_regs;
    bit            chk_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rn, input logic sv, input logic [DB-1:0] sd,
                     input logic [N-1:0] mr, input logic e_srdy, input logic [N-1:0] e_mv,
                     input logic [SB-1:0] e_sel, input logic e_tick, input logic [DB-1:0] e_data,
                     input logic [1:0] e_stall, input bit chk_regs, input bit chk_data);
    vec_t v;
    v.rn = rn; v.sv = sv; v.sd = sd; v.mr = mr;
    v.e_srdy = e_srdy; v.e_mv = e_mv; v.e_sel = e_sel; v.e_tick = e_tick;
    v.e_data = e_data; v.e_stall = e_stall; v.chk_regs = chk_regs; v.chk_data = chk_data;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    byte unsigned held[$];
    int           ptr;
    int           refused;
    bit           has;
    bit           fire;
    logic         exp_srdy;
    logic [N-1:0] exp_mv;
    logic         exp_tick;

    // Reset (first cycle outside the table; registers undefined before it).
    resetn = 1'b0; s_valid = 1'b1; s_data = 8'h55; m_ready = 4'hF;
    @(posedge clk);

    //  rn sv  sd     mr     srdy mv    sel tick data   stall regs dchk
    add(0, 1, 8'h55, 4'hF,  0,  4'h0, 0,  0,  8'h00, 0,    1,   1);
    add(0, 1, 8'h55, 4'hF,  0,  4'h0, 0,  0,  8'h00, 0,    1,   1);
    // Rotation 0x10..0x17, all lanes ready.
    add(1, 1, 8'h10, 4'hF,  1,  4'h0, 0,  0,  8'h00, 0,    1,   0);
    add(1, 1, 8'h11, 4'hF,  1,  4'h1, 0,  0,  8'h10, 0,    1,   1);
    add(1, 1, 8'h12, 4'hF,  1,  4'h2, 1,  0,  8'h11, 0,    1,   1);
    add(1, 1, 8'h13, 4'hF,  1,  4'h4, 2,  0,  8'h12, 0,    1,   1);
    add(1, 1, 8'h14, 4'hF,  1,  4'h8, 3,  1,  8'h13, 0,    1,   1);
    add(1, 1, 8'h15, 4'hF,  1,  4'h1, 0,  0,  8'h14, 0,    1,   1);
    add(1, 1, 8'h16, 4'hF,  1,  4'h2, 1,  0,  8'h15, 0,    1,   1);
    add(1, 1, 8'h17, 4'hF,  1,  4'h4, 2,  0,  8'h16, 0,    1,   1);
    add(1, 0, 8'h00, 4'hF,  1,  4'h8, 3,  1,  8'h17, 0,    1,   1);
    // Skip: lane 1 never ready.
    add(1, 1, 8'hA0, 4'hD,  1,  4'h0, 0,  0,  8'h00, 0,    1,   0);
    add(1, 1, 8'hA1, 4'hD,  1,  4'h1, 0,  0,  8'hA0, 0,    1,   1);
    add(1, 0, 8'h00, 4'hD,  0,  4'h2, 1,  0,  8'hA1, 0,    1,   1);
    add(1, 0, 8'h00, 4'hD,  0,  4'h2, 1,  0,  8'hA1, 1,    1,   1);
    add(1, 0, 8'h00, 4'hD,  0,  4'h2, 1,  0,  8'hA1, 2,    1,   1);
    add(1, 0, 8'h00, 4'hD,  1,  4'h4, 2,  0,  8'hA1, 0,    1,   1);
    add(1, 0, 8'h00, 4'hF,  1,  4'h0, 3,  0,  8'h00, 0,    1,   0);
    // Recovery: walk to lane 1, refuse twice, then accept.
    add(1, 1, 8'hB3, 4'hF,  1,  4'h0, 3,  0,  8'h00, 0,    1,   0);
    add(1, 1, 8'hB0, 4'hF,  1,  4'h8, 3,  1,  8'hB3, 0,    1,   1);
    add(1, 1, 8'hB1, 4'hF,  1,  4'h1, 0,  0,  8'hB0, 0,    1,   1);
    add(1, 0, 8'h00, 4'hD,  0,  4'h2, 1,  0,  8'hB1, 0,    1,   1);
    add(1, 0, 8'h00, 4'hD,  0,  4'h2, 1,  0,  8'hB1, 1,    1,   1);
    add(1, 0, 8'h00, 4'hF,  1,  4'h2, 1,  0,  8'hB1, 2,    1,   1);
    // Collision: lane 1 ready exactly in the limit cycle, refilled same cycle.
    add(1, 1, 8'hC2, 4'hF,  1,  4'h0, 2,  0,  8'h00, 0,    1,   0);
    add(1, 1, 8'hC3, 4'hF,  1,  4'h4, 2,  0,  8'hC2, 0,    1,   1);
    add(1, 1, 8'hC0, 4'hF,  1,  4'h8, 3,  1,  8'hC3, 0,    1,   1);
    add(1, 1, 8'hC1, 4'hF,  1,  4'h1, 0,  0,  8'hC0, 0,    1,   1);
    add(1, 0, 8'h00, 4'hD,  0,  4'h2, 1,  0,  8'hC1, 0,    1,   1);
    add(1, 0, 8'h00, 4'hD,  0,  4'h2, 1,  0,  8'hC1, 1,    1,   1);
    add(1, 1, 8'hD0, 4'hF,  1,  4'h2, 1,  0,  8'hC1, 2,    1,   1);
    // Mid-operation reset while FULL on stalled lane 2.
    add(1, 0, 8'h00, 4'hB,  0,  4'h4, 2,  0,  8'hD0, 0,    1,   1);
    add(0, 0, 8'h00, 4'hB,  0,  4'h0, 2,  0,  8'hD0, 1,    0,   0);
    add(0, 0, 8'h00, 4'hB,  0,  4'h0, 0,  0,  8'h00, 0,    1,   1);
    add(1, 0, 8'h00, 4'hF,  1,  4'h0, 0,  0,  8'h00, 0,    1,   1);
    add(1, 0, 8'h00, 4'hF,  1,  4'h0, 0,  0,  8'h00, 0,    1,   1);

    foreach (vecs[i]) begin
      @(negedge clk);
      resetn = vecs[i].rn; s_valid = vecs[i].sv; s_data = vecs[i].sd; m_ready = vecs[i].mr;
      #1;
      check($sformatf("v%0d s_ready", i), 32'(s_ready), 32'(vecs[i].e_srdy));
      check($sformatf("v%0d m_valid", i), 32'(m_valid), 32'(vecs[i].e_mv));
      check($sformatf("v%0d round_tick", i), 32'(round_tick), 32'(vecs[i].e_tick));
      if (vecs[i].chk_regs) begin
        check($sformatf("v%0d m_sel", i), 32'(m_sel), 32'(vecs[i].e_sel));
        check($sformatf("v%0d stall_cnt", i), 32'(dut.stall_cnt), 32'(vecs[i].e_stall));
      end
      if (vecs[i].chk_data)
        check($sformatf("v%0d m_data", i), 32'(m_data), 32'(vecs[i].e_data));
    end

    // Random traffic. Model: a word waits on the lane the pointer names;
    // a ready lane takes it and the pointer moves on; after SL refusals on
    // one lane the pointer moves on without handing it off.
    ptr = 0; refused = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      resetn  = 1'b1;
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = DB'($urandom);
      m_ready = N'($urandom_range(0, N * N - 1));
      if (((c / 64) % 2) == 1) m_ready[(c / 128) % N] = 1'b0;
      if ((c % 97) < 8) m_ready = '0;
      #1;
      has      = (held.size() > 0);
      fire     = has && m_ready[ptr];
      exp_srdy = !has || fire;
      exp_mv   = has ? N'(1 << ptr) : '0;
      exp_tick = fire && (ptr == N - 1);
      check($sformatf("r%0d s_ready", c), 32'(s_ready), 32'(exp_srdy));
      check($sformatf("r%0d m_valid", c), 32'(m_valid), 32'(exp_mv));
      check($sformatf("r%0d m_sel", c), 32'(m_sel), 32'(ptr));
      check($sformatf("r%0d round_tick", c), 32'(round_tick), 32'(exp_tick));
      if (has) check($sformatf("r%0d m_data", c), 32'(m_data), 32'(held[0]));
      @(posedge clk);
      if (fire) begin
        void'(held.pop_front());
        ptr = (ptr + 1) % N;
        refused = 0;
      end else if (has) begin
        refused++;
        if (refused == SL) begin
          ptr = (ptr + 1) % N;
          refused = 0;
        end
      end
      if (s_valid && exp_srdy) held.push_back(s_data);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
